// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS control sequencer and its datapath.
// ALU select codes here are the same ones the ALU decodes.
package mips_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned MADDR_W = 5;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FN_W    = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        K_RTYPE = 2'd0,
        K_SW    = 2'd1,
        K_BEQ   = 2'd2,
        K_NONE  = 2'd3
    } kind_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;

    localparam logic [FN_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FN_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FN_W-1:0] FN_MULT = 6'h18;
    localparam logic [FN_W-1:0] FN_DIV  = 6'h1A;
    localparam logic [FN_W-1:0] FN_AND  = 6'h24;
    localparam logic [FN_W-1:0] FN_OR   = 6'h25;
    localparam logic [FN_W-1:0] FN_NOR  = 6'h27;
    localparam logic [FN_W-1:0] FN_SLT  = 6'h2A;

    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b111;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b110;
    localparam logic [ALU_W-1:0] ALU_MULT = 3'b100;
    localparam logic [ALU_W-1:0] ALU_DIV  = 3'b000;
    localparam logic [ALU_W-1:0] ALU_AND  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_OR   = 3'b001;
    localparam logic [ALU_W-1:0] ALU_NOR  = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SLT  = 3'b101;

    typedef struct packed {
        logic [ALU_W-1:0] alu_sel;
        kind_e            kind;
        logic             legal;
    } dec_t;

    // Fields kept from the accepted instruction for the rest of its lifetime
    typedef struct packed {
        kind_e              kind;
        logic [ALU_W-1:0]   alu_sel;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] rd;
        logic [MADDR_W-1:0] maddr;
    } cap_t;

    function automatic logic [OP_W-1:0] instr_op(input logic [DATA_W-1:0] w);
        return w[31:26];
    endfunction

    function automatic logic [FN_W-1:0] instr_funct(input logic [DATA_W-1:0] w);
        return w[5:0];
    endfunction

    function automatic logic [RADDR_W-1:0] instr_rs(input logic [DATA_W-1:0] w);
        return w[25:21];
    endfunction

    function automatic logic [RADDR_W-1:0] instr_rt(input logic [DATA_W-1:0] w);
        return w[20:16];
    endfunction

    function automatic logic [RADDR_W-1:0] instr_rd(input logic [DATA_W-1:0] w);
        return w[15:11];
    endfunction

    function automatic logic [MADDR_W-1:0] instr_maddr(input logic [DATA_W-1:0] w);
        return w[MADDR_W-1:0];
    endfunction

endpackage

// File: rtl/mips_ctrl_seq_if.sv
// Instruction-source and datapath-control bundle of the MIPS control sequencer.
// slave is the sequencer side; master is the source/datapath side.
interface mips_ctrl_seq_if;
    import mips_ctrl_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    logic [DATA_W-1:0]   instr;
    logic                zf;
    logic [RADDR_W-1:0]  ra1;
    logic [RADDR_W-1:0]  ra2;
    logic [ALU_W-1:0]    alu_sel;
    logic [RADDR_W-1:0]  wa;
    logic                reg_write;
    logic                mem_wr;
    logic [MADDR_W-1:0]  mem_addr;
    logic                branch_taken;
    logic                illegal;
    logic                done;

    modport slave (
        input  instr_valid, instr, zf,
        output instr_ready, ra1, ra2, alu_sel, wa, reg_write, mem_wr,
               mem_addr, branch_taken, illegal, done
    );

    modport master (
        output instr_valid, instr, zf,
        input  instr_ready, ra1, ra2, alu_sel, wa, reg_write, mem_wr,
               mem_addr, branch_taken, illegal, done
    );

endinterface

// File: rtl/mips_ctrl_dec.sv
// Combinational opcode/funct decode into ALU select, instruction kind and legality.
module mips_ctrl_dec
    import mips_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [FN_W-1:0] funct,
    output dec_t            dec_c
);

    always_comb begin
        dec_c.alu_sel = ALU_DIV;
        dec_c.kind    = K_NONE;
        dec_c.legal   = 1'b0;

        case (op)
            OP_RTYPE: begin
                dec_c.kind  = K_RTYPE;
                dec_c.legal = 1'b1;
                case (funct)
                    FN_ADD:  dec_c.alu_sel = ALU_ADD;
                    FN_SUB:  dec_c.alu_sel = ALU_SUB;
                    FN_MULT: dec_c.alu_sel = ALU_MULT;
                    FN_DIV:  dec_c.alu_sel = ALU_DIV;
                    FN_AND:  dec_c.alu_sel = ALU_AND;
                    FN_OR:   dec_c.alu_sel = ALU_OR;
                    FN_NOR:  dec_c.alu_sel = ALU_NOR;
                    FN_SLT:  dec_c.alu_sel = ALU_SLT;
                    default: begin
                        dec_c.kind  = K_NONE;
                        dec_c.legal = 1'b0;
                    end
                endcase
            end
            // Both compare through a subtract so zf is meaningful for beq
            OP_SW: begin
                dec_c.kind    = K_SW;
                dec_c.alu_sel = ALU_SUB;
                dec_c.legal   = 1'b1;
            end
            OP_BEQ: begin
                dec_c.kind    = K_BEQ;
                dec_c.alu_sel = ALU_SUB;
                dec_c.legal   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_seq.sv
// Multi-cycle control sequencer: accepts one instruction, walks DECODE/EXEC/WB
// and issues register/memory write strobes, branch and completion pulses.
module mips_ctrl_seq
    import mips_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mips_ctrl_seq_if.slave  bus
);

    state_e state_q, state_d;
    cap_t   cap_q, cap_d;
    dec_t   dec_c;

    logic instr_ready_q,  instr_ready_d;
    logic reg_write_q,    reg_write_d;
    logic mem_wr_q,       mem_wr_d;
    logic branch_taken_q, branch_taken_d;
    logic illegal_q,      illegal_d;
    logic done_q,         done_d;

    logic accept_c;
    logic unused_shamt_c;

    assign unused_shamt_c = ^bus.instr[10:6];

    mips_ctrl_dec u_dec (
        .op    (instr_op(bus.instr)),
        .funct (instr_funct(bus.instr)),
        .dec_c (dec_c)
    );

    assign accept_c = bus.instr_valid && instr_ready_q;

    // Outputs are loaded one edge early so each registered value lines up with its state
    always_comb begin
        state_d        = state_q;
        cap_d          = cap_q;
        instr_ready_d  = 1'b0;
        reg_write_d    = 1'b0;
        mem_wr_d       = 1'b0;
        branch_taken_d = 1'b0;
        illegal_d      = 1'b0;
        done_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                instr_ready_d = 1'b1;
                if (accept_c) begin
                    state_d       = S_DECODE;
                    instr_ready_d = 1'b0;
                    illegal_d     = !dec_c.legal;
                    cap_d.kind    = dec_c.kind;
                    cap_d.alu_sel = dec_c.alu_sel;
                    cap_d.rs      = instr_rs(bus.instr);
                    cap_d.rt      = instr_rt(bus.instr);
                    cap_d.rd      = instr_rd(bus.instr);
                    cap_d.maddr   = instr_maddr(bus.instr);
                end
            end
            S_DECODE: begin
                if (illegal_q) begin
                    state_d       = S_IDLE;
                    instr_ready_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d        = S_WB;
                done_d         = 1'b1;
                reg_write_d    = (cap_q.kind == K_RTYPE) && (cap_q.rd != '0);
                mem_wr_d       = (cap_q.kind == K_SW);
                branch_taken_d = (cap_q.kind == K_BEQ) && bus.zf;
            end
            S_WB: begin
                state_d       = S_IDLE;
                instr_ready_d = 1'b1;
            end
            default: begin
                state_d       = S_IDLE;
                instr_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cap_q          <= '0;
            instr_ready_q  <= 1'b1;
            reg_write_q    <= 1'b0;
            mem_wr_q       <= 1'b0;
            branch_taken_q <= 1'b0;
            illegal_q      <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cap_q          <= cap_d;
            instr_ready_q  <= instr_ready_d;
            reg_write_q    <= reg_write_d;
            mem_wr_q       <= mem_wr_d;
            branch_taken_q <= branch_taken_d;
            illegal_q      <= illegal_d;
            done_q         <= done_d;
        end
    end

    assign bus.instr_ready  = instr_ready_q;
    assign bus.ra1          = cap_q.rs;
    assign bus.ra2          = cap_q.rt;
    assign bus.wa           = cap_q.rd;
    assign bus.alu_sel      = cap_q.alu_sel;
    assign bus.mem_addr     = cap_q.maddr;
    assign bus.reg_write    = reg_write_q;
    assign bus.mem_wr       = mem_wr_q;
    assign bus.branch_taken = branch_taken_q;
    assign bus.illegal      = illegal_q;
    assign bus.done         = done_q;

endmodule
